// File: rtl/sigmoid_logit.sv
// Inverse piecewise-linear sigmoid: maps a probability code back to a signed logit.
// 3-stage valid/ready pipeline; optional range-error counter via SIGMOID_LOGIT_ERRCNT_EN.
module sigmoid_logit #(
  parameter int unsigned SIG_ONE = 1874,
  parameter int unsigned X_SAT   = 13558
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SIGMOID_LOGIT_ERRCNT_EN
  input  logic        err_clr,
  output logic [15:0] err_cnt,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x,
  output logic        sat,
  output logic        range_err
);

  localparam int unsigned HALF = SIG_ONE >> 1;

  logic        w_en;

  logic        w_s1_rerr;
  logic [10:0] w_s1_yc;
  logic        w_s1_neg;
  logic [10:0] w_s1_ym;

  logic [10:0] w_s2_yk;
  logic [14:0] w_s2_xk;
  logic [3:0]  w_s2_sk;
  logic        w_s2_sat;
  logic [10:0] w_s2_diff;

  logic [31:0] w_xp;
  logic [31:0] w_x;

  logic        r_s1_valid;
  logic        r_s1_neg;
  logic        r_s1_rerr;
  logic [10:0] r_s1_ym;

  logic        r_s2_valid;
  logic        r_s2_neg;
  logic        r_s2_rerr;
  logic        r_s2_sat;
  logic [14:0] r_s2_xk;
  logic [10:0] r_s2_diff;
  logic [3:0]  r_s2_sk;

  logic        r_out_valid;
  logic [31:0] r_x;
  logic        r_sat;
  logic        r_range_err;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign x         = r_x;
  assign sat       = r_sat;
  assign range_err = r_range_err;

  // S1: clamp to SIG_ONE and fold the lower half onto the upper half.
  always_comb begin
    w_s1_rerr = (y > SIG_ONE);
    w_s1_yc   = w_s1_rerr ? 11'(SIG_ONE) : y[10:0];
    w_s1_neg  = (w_s1_yc < 11'(HALF));
    w_s1_ym   = w_s1_neg ? (11'(SIG_ONE) - w_s1_yc) : w_s1_yc;
  end

  // S2: breakpoint search, highest segment first.
  always_comb begin
    w_s2_yk  = 11'd937;
    w_s2_xk  = 15'd0;
    w_s2_sk  = 4'd2;
    w_s2_sat = 1'b0;
    if (r_s1_ym >= 11'd1872) begin
      w_s2_yk  = r_s1_ym;
      w_s2_xk  = 15'(X_SAT);
      w_s2_sk  = 4'd0;
      w_s2_sat = 1'b1;
    end else if (r_s1_ym >= 11'd1867) begin
      w_s2_yk = 11'd1867; w_s2_xk = 15'd10954; w_s2_sk = 4'd9;
    end else if (r_s1_ym >= 11'd1862) begin
      w_s2_yk = 11'd1862; w_s2_xk = 15'd9644;  w_s2_sk = 4'd8;
    end else if (r_s1_ym >= 11'd1852) begin
      w_s2_yk = 11'd1852; w_s2_xk = 15'd8323;  w_s2_sk = 4'd7;
    end else if (r_s1_ym >= 11'd1831) begin
      w_s2_yk = 11'd1831; w_s2_xk = 15'd6978;  w_s2_sk = 4'd6;
    end else if (r_s1_ym >= 11'd1788) begin
      w_s2_yk = 11'd1788; w_s2_xk = 15'd5578;  w_s2_sk = 4'd5;
    end else if (r_s1_ym >= 11'd1693) begin
      w_s2_yk = 11'd1693; w_s2_xk = 15'd4055;  w_s2_sk = 4'd4;
    end else if (r_s1_ym >= 11'd1436) begin
      w_s2_yk = 11'd1436; w_s2_xk = 15'd1996;  w_s2_sk = 4'd3;
    end
    w_s2_diff = r_s1_ym - w_s2_yk;
  end

  // S3: one's-complement mirror matches the forward sigmoid's negative fold.
  always_comb begin
    w_xp = {17'd0, r_s2_xk} + ({21'd0, r_s2_diff} << r_s2_sk);
    w_x  = r_s2_neg ? ~w_xp : w_xp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_neg    <= 1'b0;
      r_s1_rerr   <= 1'b0;
      r_s1_ym     <= 11'd0;
      r_s2_valid  <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_s2_rerr   <= 1'b0;
      r_s2_sat    <= 1'b0;
      r_s2_xk     <= 15'd0;
      r_s2_diff   <= 11'd0;
      r_s2_sk     <= 4'd0;
      r_out_valid <= 1'b0;
      r_x         <= 32'd0;
      r_sat       <= 1'b0;
      r_range_err <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_neg  <= w_s1_neg;
        r_s1_rerr <= w_s1_rerr;
        r_s1_ym   <= w_s1_ym;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_neg  <= r_s1_neg;
        r_s2_rerr <= r_s1_rerr;
        r_s2_sat  <= w_s2_sat;
        r_s2_xk   <= w_s2_xk;
        r_s2_diff <= w_s2_diff;
        r_s2_sk   <= w_s2_sk;
      end
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_x         <= w_x;
        r_sat       <= r_s2_sat;
        r_range_err <= r_s2_rerr;
      end
    end
  end

`ifdef SIGMOID_LOGIT_ERRCNT_EN
  logic [15:0] r_err_cnt;

  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      r_err_cnt <= 16'd0;
    end else if (r_out_valid && out_ready && r_range_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`endif

endmodule
